muldiv_iter: RTL and testbench

- Iterative integer multiply/divide unit implementing the RV32M op set, parametrised in WIDTH.
- Sits beside the combinational integer ALU in the execute stage.
- Takes one operation at a time through a valid/ready handshake and returns the result through a second valid/ready handshake.
- Multiply uses radix-2 shift-add; divide uses radix-2 restoring division on magnitudes, with sign fix-up at the end.

---
 rtl/muldiv_iter_if.sv | 23 ++
 rtl/muldiv_iter.sv | 127 ++++++++++++
 tb/tb_muldiv_iter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;

  modport master (
    output in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, rd
  );

  modport slave (
    input  in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, rd
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, radix-2 restoring
// divide on magnitudes, sign fix-up in a final cycle.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  muldiv_iter_if.slave bus,
  output logic         busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               fix;
  logic               fast_q;
  logic               neg_q;
  logic [2:0]         op_q;

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic             div0, ovf, fast, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag, fast_val;

  always_comb begin
    is_div   = bus.op[2];
    a_sgn    = is_div ? ~bus.op[0] : (bus.op != 3'd3);
    b_sgn    = is_div ? ~bus.op[0] : ~bus.op[1];
    a_neg    = a_sgn & bus.rs1[WIDTH-1];
    b_neg    = b_sgn & bus.rs2[WIDTH-1];
    a_mag    = a_neg ? ('0 - bus.rs1) : bus.rs1;
    b_mag    = b_neg ? ('0 - bus.rs2) : bus.rs2;
    div0     = (bus.rs2 == '0);
    ovf      = is_div & ~bus.op[0] & (bus.rs1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.rs2);
    fast     = is_div & (div0 | ovf);
    if (div0) fast_val = bus.op[1] ? bus.rs1 : '1;
    else      fast_val = bus.op[1] ? '0 : bus.rs1;
    // REM/REMU follow the dividend sign; everything else follows the sign product
    neg_in   = (is_div & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   div_sel, res;

  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    prod_neg  = neg_q ? ('0 - prod) : prod;
    div_sel   = op_q[1] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    if (fast_q)                 res = prod[WIDTH-1:0];
    else if (op_q[2])           res = neg_q ? ('0 - div_sel) : div_sel;
    else if (op_q[1:0] == 2'd0) res = prod_neg[WIDTH-1:0];
    else                        res = prod_neg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      prod          <= '0;
      mcand         <= '0;
      cnt           <= '0;
      fix           <= 1'b0;
      fast_q        <= 1'b0;
      neg_q         <= 1'b0;
      op_q          <= '0;
      if (!rst_n) bus.rd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q         <= bus.op;
            neg_q        <= neg_in;
            mcand        <= is_div ? b_mag : a_mag;
            // fast-path results park in prod and use the fix-up cycle directly
            prod         <= {{WIDTH{1'b0}}, fast ? fast_val : (is_div ? a_mag : b_mag)};
            fast_q       <= fast;
            fix          <= fast;
            cnt          <= fast ? '0 : CW'(WIDTH - 1);
            state        <= BUSY;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        BUSY: begin
          if (fix) begin
            bus.rd        <= res;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            if (op_q[2]) begin
              if (!div_diff[WIDTH]) prod <= {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
              else                  prod <= {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
            end else begin
              prod <= {mul_sum, prod[WIDTH-1:1]};
            end
            if (cnt == '0) fix <= 1'b1;
            else           cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed vector table, handshake/flush/reset sequences,
// and randomised ops at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_muldiv_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy32, busy8;

  muldiv_iter_if #(.WIDTH(32)) b32();
  muldiv_iter_if #(.WIDTH(8))  b8();

  muldiv_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .busy(busy32));
  muldiv_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b8),  .busy(busy8));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] refm(input int w, input logic [2:0] o,
                                       input logic [63:0] a, input logic [63:0] b);
    longint unsigned mask, ua, ub;
    longint sa, sb, p, mn;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    mn = -longint'(64'd1 << (w - 1));
    case (o)
      3'd0: begin p = sa * sb; return p & mask; end
      3'd1: begin p = sa * sb; p = p >>> w; return p & mask; end
      3'd2: begin p = sa * longint'(ub); p = p >>> w; return p & mask; end
      3'd3: return ((ua * ub) >> w) & mask;
      3'd4: begin
        if (ub == 0) return mask;
        if (sa == mn && sb == -1) return ua;
        p = sa / sb; return p & mask;
      end
      3'd5: return (ub == 0) ? mask : (ua / ub);
      3'd6: begin
        if (ub == 0) return ua;
        if (sa == mn && sb == -1) return 64'd0;
        p = sa % sb; return p & mask;
      end
      default: return (ub == 0) ? ua : (ua % ub);
    endcase
  endfunction

  function automatic bit isfast(input int w, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (!o[2]) return 1'b0;
    if ((b & mask) == 0) return 1'b1;
    return !o[0] && ((a & mask) == (64'd1 << (w - 1))) && ((b & mask) == mask);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return mask;
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      default: return $urandom() & mask;
    endcase
  endfunction

  task automatic txn32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] r, output int lat);
    int guard = 0;
    while (b32.in_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    b32.in_valid = 1'b1; b32.op = o; b32.rs1 = a; b32.rs2 = b;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    r = b32.rd;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall32_rd", b32.rd, r);
      check("stall32_valid", b32.out_valid, 1);
      check("stall32_in_ready", b32.in_ready, 0);
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic txn8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input int stall, output logic [7:0] r, output int lat);
    int guard = 0;
    while (b8.in_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    b8.in_valid = 1'b1; b8.op = o; b8.rs1 = a; b8.rs2 = b;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    r = b8.rd;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall8_rd", b8.rd, r);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r32, a32, c32;
    logic [7:0]  r8, a8, c8;
    logic [2:0]  o;
    int lat, seen;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33});
    vecs.push_back('{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 33});
    vecs.push_back('{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33});
    vecs.push_back('{3'd6, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});

    b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.op = '0; b32.rs1 = '0; b32.rs2 = '0;
    b8.in_valid  = 1'b0; b8.out_ready  = 1'b0; b8.op  = '0; b8.rs1  = '0; b8.rs2  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", b32.in_ready, 1);
    check("rst_out_valid", b32.out_valid, 0);
    check("rst_busy", busy32, 0);
    check("rst_rd", b32.rd, 0);
    check("rst8_in_ready", b8.in_ready, 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn32(vecs[i].op, vecs[i].a, vecs[i].b, 0, r32, lat);
      check($sformatf("vec%0d_rd", i), r32, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // backpressure: result held for 10 cycles
    txn32(3'd0, 32'h0000_1234, 32'h0000_0010, 10, r32, lat);
    check("bp_rd", r32, 32'h0001_2340);
    check("bp_lat", lat, 33);

    // out_ready and in_valid together in DONE: only the result handshake completes
    b32.in_valid = 1'b1; b32.op = 3'd0; b32.rs1 = 32'd3; b32.rs2 = 32'd5;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("done_first_rd", b32.rd, 32'd15);
    b32.out_ready = 1'b1; b32.in_valid = 1'b1; b32.rs1 = 32'd2; b32.rs2 = 32'd9;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    check("done_in_valid_drop", b32.out_valid, 0);
    check("done_in_idle_ready", b32.in_ready, 1);
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    check("done_next_accept", b32.in_ready, 0);
    lat = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("done_second_lat", lat, 33);
    check("done_second_rd", b32.rd, 32'd18);
    b32.out_ready = 1'b1; @(posedge clk); #1; b32.out_ready = 1'b0;

    // flush mid-DIV
    b32.in_valid = 1'b1; b32.op = 3'd4; b32.rs1 = 32'd1000; b32.rs2 = 32'd7;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", b32.out_valid, 0);
    check("flush_in_ready", b32.in_ready, 1);
    check("flush_busy", busy32, 0);
    check("flush_rd_hold", b32.rd, 32'd18);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (b32.out_valid === 1'b1) seen++; end
    check("flush_no_valid", seen, 0);
    flush = 1'b1; b32.in_valid = 1'b1; b32.op = 3'd0; b32.rs1 = 32'd9; b32.rs2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; b32.in_valid = 1'b0;
    check("flush_idle_no_accept", b32.in_ready, 1);
    check("flush_idle_busy", busy32, 0);
    txn32(3'd0, 32'd6, 32'd7, 0, r32, lat);
    check("flush_mul_rd", r32, 32'd42);
    check("flush_mul_lat", lat, 33);

    // reset mid-DIV
    b32.in_valid = 1'b1; b32.op = 3'd4; b32.rs1 = 32'hFFFF_FC18; b32.rs2 = 32'd3;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_in_ready", b32.in_ready, 1);
    check("mrst_out_valid", b32.out_valid, 0);
    check("mrst_busy", busy32, 0);
    check("mrst_rd", b32.rd, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (b32.out_valid === 1'b1) seen++; end
    check("mrst_no_valid", seen, 0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a32 = pick(32);
      c32 = pick(32);
      txn32(o, a32, c32, $urandom_range(0, 3), r32, lat);
      check($sformatf("r32_op%0d_%h_%h", o, a32, c32), r32, refm(32, o, a32, c32) & 64'hFFFF_FFFF);
      check("r32_lat", lat, isfast(32, o, a32, c32) ? 1 : 33);
    end

    for (int i = 0; i < 200; i++) begin
      o = 3'($urandom_range(0, 7));
      a32 = pick(8);
      c32 = pick(8);
      a8 = a32[7:0];
      c8 = c32[7:0];
      txn8(o, a8, c8, $urandom_range(0, 2), r8, lat);
      check($sformatf("r8_op%0d_%h_%h", o, a8, c8), r8, refm(8, o, a32, c32) & 64'hFF);
      check("r8_lat", lat, isfast(8, o, a32, c32) ? 1 : 9);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
